// File: rtl/ddr_frame_pkg.sv
// rtl/ddr_frame_pkg.sv - shared frame-store constants, MIG command codes and reader state encoding
package ddr_frame_pkg;

    localparam logic [29:0] BUF0_BASE   = 30'd0;
    localparam logic [29:0] BUF1_BASE   = 30'd70560;
    localparam int          FRAME_WORDS = 17640;

    localparam logic [2:0]  MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0]  MIG_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_CALIB      = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_STREAM     = 2'd2,
        ST_FLUSH      = 2'd3
    } rd_state_e;

endpackage

// File: rtl/ddr_read_credit.sv
// rtl/ddr_read_credit.sv - outstanding-word counter bounding read commands to the MIG read FIFO depth
module ddr_read_credit #(
    parameter int FIFO_WORDS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic [6:0] issue_n,
    input  logic       pop,
    output logic       can_issue,
    output logic       is_zero
);

    logic [6:0] outst_q, outst_d;
    logic [7:0] outst_sum;
    logic       pop_eff;

    // Credit check for the burst being offered, plus the counter update for issue/pop.
    always_comb begin
        outst_sum = {1'b0, outst_q} + {1'b0, issue_n};
        can_issue = (outst_sum <= 8'(FIFO_WORDS));
        is_zero   = (outst_q == 7'd0);
        // Stale words left over from before a reset must not wrap the counter below zero.
        pop_eff   = pop && (outst_q != 7'd0);
        outst_d   = outst_q;
        case ({issue, pop_eff})
            2'b10:   outst_d = outst_q + issue_n;
            2'b01:   outst_d = outst_q - 7'd1;
            2'b11:   outst_d = outst_q + issue_n - 7'd1;
            default: outst_d = outst_q;
        endcase
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            outst_q <= 7'd0;
        end else begin
            outst_q <= outst_d;
        end
    end

endmodule

// File: rtl/ddr_port1_frame_reader.sv
// rtl/ddr_port1_frame_reader.sv - streams the displayed DDR frame buffer out through MIG port 1
module ddr_port1_frame_reader
    import ddr_frame_pkg::*;
#(
    parameter int BURST_LEN  = 32,
    parameter int FIFO_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_calib_done,
    input  logic        frame_swap,
    input  logic        frame_start,
    input  logic        p1_cmd_full,
    output logic        p1_cmd_en,
    output logic [2:0]  p1_cmd_instr,
    output logic [5:0]  p1_cmd_bl,
    output logic [29:0] p1_cmd_byte_addr,
    input  logic        p1_rd_empty,
    input  logic [31:0] p1_rd_data,
    output logic        p1_rd_en,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_req,
    output logic        underrun
);

    localparam logic [14:0] FRAME_W = 15'(FRAME_WORDS);
    localparam logic [14:0] BURST_W = 15'(BURST_LEN);
    localparam logic [6:0]  BURST_N = 7'(BURST_LEN);

    rd_state_e   state_q, state_d;
    logic        calib_meta_q, calib_meta_d;
    logic        calib_sync_q, calib_sync_d;
    logic        rd_buf_q, rd_buf_d;
    logic        swap_pend_q, swap_pend_d;
    logic [14:0] issued_q, issued_d;
    logic [14:0] word_ptr_q, word_ptr_d;
    logic        cmd_en_last_q, cmd_en_last_d;
    logic [31:0] data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        underrun_q, underrun_d;

    logic [14:0] remaining;
    logic [6:0]  burst_n;
    logic [29:0] base_addr;
    logic        issue;
    logic        pop;
    logic        can_issue;
    logic        credit_zero;

    ddr_read_credit #(
        .FIFO_WORDS (FIFO_WORDS)
    ) u_credit (
        .clk       (clk),
        .reset     (reset),
        .issue     (issue),
        .issue_n   (burst_n),
        .pop       (pop),
        .can_issue (can_issue),
        .is_zero   (credit_zero)
    );

    // Burst sizing, command issue and read-FIFO pop; issue is blocked on the frame_start cycle
    // so a restarting frame never sees a command computed from the old frame's pointer.
    always_comb begin
        remaining = FRAME_W - issued_q;
        burst_n   = (remaining > BURST_W) ? BURST_N : remaining[6:0];
        base_addr = rd_buf_q ? BUF1_BASE : BUF0_BASE;
        issue     = (state_q == ST_STREAM) && !frame_start && !cmd_en_last_q &&
                    (burst_n != 7'd0) && !p1_cmd_full && can_issue;
        pop       = !p1_rd_empty &&
                    ((state_q == ST_FLUSH) ||
                     ((state_q == ST_STREAM) && (!data_valid_q || data_req)));

        p1_cmd_en        = issue;
        p1_cmd_instr     = MIG_CMD_READ;
        p1_cmd_bl        = issue ? 6'(burst_n - 7'd1) : 6'd0;
        p1_cmd_byte_addr = issue ? (base_addr + {13'd0, issued_q, 2'b00}) : 30'd0;
        p1_rd_en         = pop;
    end

    // Next-state logic: calibration sync, frame FSM, buffer swap and the output word register.
    always_comb begin
        state_d       = state_q;
        calib_meta_d  = mem_calib_done;
        calib_sync_d  = calib_meta_q;
        rd_buf_d      = rd_buf_q;
        swap_pend_d   = swap_pend_q;
        issued_d      = issued_q;
        word_ptr_d    = word_ptr_q;
        cmd_en_last_d = issue;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        underrun_d    = underrun_q;

        if (issue) begin
            issued_d = issued_q + {8'd0, burst_n};
        end

        if (pop && (state_q == ST_STREAM)) begin
            data_out_d   = p1_rd_data;
            data_valid_d = 1'b1;
            word_ptr_d   = word_ptr_q + 15'd1;
        end else if (data_req && data_valid_q) begin
            data_valid_d = 1'b0;
        end

        if ((state_q == ST_STREAM) && data_req && !data_valid_q) begin
            underrun_d = 1'b1;
        end

        case (state_q)
            ST_CALIB: begin
                if (calib_sync_q) begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_start) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (frame_start) begin
                    state_d = credit_zero ? ST_STREAM : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                data_valid_d = 1'b0;
                if (credit_zero) begin
                    state_d = ST_STREAM;
                end
            end
            default: state_d = ST_CALIB;
        endcase

        if (frame_start) begin
            if (swap_pend_q) begin
                rd_buf_d    = ~rd_buf_q;
                swap_pend_d = 1'b0;
            end
            issued_d     = 15'd0;
            word_ptr_d   = 15'd0;
            data_valid_d = 1'b0;
        end

        // A swap request arriving with frame_start stays pending for the following frame.
        if (frame_swap) begin
            swap_pend_d = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_CALIB;
            calib_meta_q  <= 1'b0;
            calib_sync_q  <= 1'b0;
            rd_buf_q      <= 1'b1;
            swap_pend_q   <= 1'b0;
            issued_q      <= 15'd0;
            word_ptr_q    <= 15'd0;
            cmd_en_last_q <= 1'b0;
            data_out_q    <= 32'd0;
            data_valid_q  <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            calib_meta_q  <= calib_meta_d;
            calib_sync_q  <= calib_sync_d;
            rd_buf_q      <= rd_buf_d;
            swap_pend_q   <= swap_pend_d;
            issued_q      <= issued_d;
            word_ptr_q    <= word_ptr_d;
            cmd_en_last_q <= cmd_en_last_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            underrun_q    <= underrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_ddr_port1_frame_reader.sv
// tb/tb_ddr_port1_frame_reader.sv - scoreboard bench for the DDR port-1 frame reader
module tb_ddr_port1_frame_reader;

    localparam int FW   = 17640;
    localparam int BUF1 = 70560;

    logic        clk = 1'b0;
    logic        reset, mem_calib_done, frame_swap, frame_start, p1_cmd_full, data_req;
    logic        p1_rd_empty = 1'b1;
    logic [31:0] p1_rd_data  = 32'd0;
    logic        p1_cmd_en, p1_rd_en, data_valid, underrun;
    logic [2:0]  p1_cmd_instr;
    logic [5:0]  p1_cmd_bl;
    logic [29:0] p1_cmd_byte_addr;
    logic [31:0] data_out;

    int n_pass = 0;
    int n_checks = 0;

    ddr_port1_frame_reader dut (
        .clk              (clk),
        .reset            (reset),
        .mem_calib_done   (mem_calib_done),
        .frame_swap       (frame_swap),
        .frame_start      (frame_start),
        .p1_cmd_full      (p1_cmd_full),
        .p1_cmd_en        (p1_cmd_en),
        .p1_cmd_instr     (p1_cmd_instr),
        .p1_cmd_bl        (p1_cmd_bl),
        .p1_cmd_byte_addr (p1_cmd_byte_addr),
        .p1_rd_empty      (p1_rd_empty),
        .p1_rd_data       (p1_rd_data),
        .p1_rd_en         (p1_rd_en),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .data_req         (data_req),
        .underrun         (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return 32'(a) ^ 32'h5A5A_0000;
    endfunction

    // DDR / MIG port model
    logic [31:0] rdq[$];
    logic [31:0] pend[$];
    logic        cmd_en_s = 1'b0, rd_en_s = 1'b0;
    logic [5:0]  bl_s = 6'd0;
    logic [29:0] addr_s = 30'd0;
    int          total_cmds = 0;
    int          occ;
    int          cmd_addr_log[$];
    int          cmd_bl_log[$];
    int          cmd_occ_log[$];

    function automatic int log_addr(input int idx);
        if (idx >= 0 && idx < cmd_addr_log.size()) return cmd_addr_log[idx];
        return -1;
    endfunction
    function automatic int log_bl(input int idx);
        if (idx >= 0 && idx < cmd_bl_log.size()) return cmd_bl_log[idx];
        return -1;
    endfunction
    function automatic int log_occ(input int idx);
        if (idx >= 0 && idx < cmd_occ_log.size()) return cmd_occ_log[idx];
        return -1;
    endfunction

    always @(posedge clk) begin
        #1;
        if (reset) begin
            rdq.delete();
            pend.delete();
        end else begin
            if (rd_en_s) begin
                if (rdq.size() > 0) void'(rdq.pop_front());
                else check("pop_on_empty", 1, 0);
            end
            if (pend.size() > 0) rdq.push_back(pend.pop_front());
            if (cmd_en_s) begin
                occ = rdq.size() + pend.size();
                cmd_addr_log.push_back(int'(addr_s));
                cmd_bl_log.push_back(int'(bl_s));
                cmd_occ_log.push_back(occ);
                total_cmds++;
                check("credit_bound", (occ + int'(bl_s) + 1 <= 64) ? 1 : 0, 1);
                check("addr_align", addr_s[1:0], 0);
                for (int i = 0; i <= int'(bl_s); i++) pend.push_back(mem_word(int'(addr_s) + 4 * i));
            end
        end
        p1_rd_empty = (rdq.size() == 0);
        p1_rd_data  = (rdq.size() == 0) ? 32'd0 : rdq[0];
    end

    // Scoreboard: expected frame words are queued when a frame_start is issued
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    int fs_seq = 0, seen_seq = 0, fs_base = 0;
    int total_consumed = 0;
    int bp_hits = 0;

    always @(negedge clk) begin
        cmd_en_s = p1_cmd_en;
        bl_s     = p1_cmd_bl;
        addr_s   = p1_cmd_byte_addr;
        rd_en_s  = p1_rd_en;
        if (p1_cmd_full && p1_cmd_en) bp_hits++;
        if (fs_seq != seen_seq) begin
            seen_seq = fs_seq;
            exp_q.delete();
            for (int i = 0; i < FW; i++) exp_q.push_back(mem_word(fs_base + 4 * i));
        end
        if (data_valid && data_req) begin
            total_consumed++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_extra_word: actual %08h required no word", data_out);
            end else begin
                exp_w = exp_q.pop_front();
                check("sb_word", data_out, exp_w);
            end
        end
    end

    // Stimulus
    bit buf_m = 1'b1;
    bit swap_pend_m = 1'b0;
    int cmd_base = 0, cons_base = 0;
    int cyc, c0, bp0;
    bit flag;

    task automatic pulse_frame_start(input logic req);
        @(posedge clk); #1;
        frame_start = 1'b1;
        data_req    = req;
        @(posedge clk); #2;
        frame_start = 1'b0;
        if (swap_pend_m) begin
            buf_m       = ~buf_m;
            swap_pend_m = 1'b0;
        end
        fs_base   = buf_m ? BUF1 : 0;
        fs_seq++;
        cmd_base  = total_cmds;
        cons_base = total_consumed;
    endtask

    task automatic pulse_frame_swap();
        @(posedge clk); #1 frame_swap = 1'b1;
        @(posedge clk); #1 frame_swap = 1'b0;
        swap_pend_m = 1'b1;
    endtask

    task automatic wait_consumed(input int target, input int budget);
        cyc = 0;
        while ((total_consumed - cons_base) < target && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; mem_calib_done = 1'b0; frame_swap = 1'b0; frame_start = 1'b0;
        p1_cmd_full = 1'b0; data_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_en", p1_cmd_en, 0);
        check("rst_cmd_instr", p1_cmd_instr, 1);
        check("rst_cmd_bl", p1_cmd_bl, 0);
        check("rst_cmd_addr", p1_cmd_byte_addr, 0);
        check("rst_rd_en", p1_rd_en, 0);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_underrun", underrun, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Calibration: nothing issued before the first frame_start
        repeat (10) @(posedge clk);
        #1 mem_calib_done = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("calib_no_cmd", total_cmds, 0);
        check("calib_no_underrun", underrun, 0);

        // Full frame with a consumer that always requests
        pulse_frame_start(1'b1);
        wait_consumed(FW, 30000);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("frame_words", total_consumed - cons_base, FW);
        check("frame_cmds", total_cmds - cmd_base, 552);
        check("frame_first_addr", log_addr(cmd_base), BUF1);
        check("frame_first_bl", log_bl(cmd_base), 31);
        check("frame_last_bl", log_bl(total_cmds - 1), 7);
        check("frame_sb_drained", exp_q.size(), 0);
        check("frame_end_valid", data_valid, 0);
        check("underrun_set", underrun, 1);

        // Credit limit: no consumer, only 64 words may be commanded
        pulse_frame_start(1'b0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("credit_cmds", total_cmds - cmd_base, 2);
        check("credit_fifo_words", rdq.size() + pend.size(), 63);
        check("credit_hold_valid", data_valid, 1);
        check("underrun_sticky", underrun, 1);

        // Swap request mid-frame must not disturb the frame in progress
        pulse_frame_swap();
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("credit_still_2", total_cmds - cmd_base, 2);
        @(posedge clk); #1 data_req = 1'b1;
        wait_consumed(100, 3000);
        check("mid_frame_words", ((total_consumed - cons_base) >= 100) ? 1 : 0, 1);

        // Abort: flush in-flight words, then restart from the swapped buffer
        pulse_frame_start(1'b0);
        flag = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (data_valid) flag = 1'b1;
        end
        check("flush_valid_low", flag, 0);
        cyc = 0;
        while (total_cmds <= cmd_base && cyc < 1000) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        check("swap_first_addr", log_addr(cmd_base), 0);
        check("flush_drained", log_occ(cmd_base), 0);
        @(posedge clk); #1 data_req = 1'b1;
        wait_consumed(200, 3000);
        check("swap_frame_words", ((total_consumed - cons_base) >= 200) ? 1 : 0, 1);

        // Command FIFO backpressure
        @(posedge clk); #1 p1_cmd_full = 1'b1;
        #1 c0 = total_cmds; bp0 = bp_hits;
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("bp_no_cmd_en", bp_hits - bp0, 0);
        check("bp_no_cmd_logged", total_cmds - c0, 0);
        check("bp_drained_valid", data_valid, 0);
        @(posedge clk); #1 p1_cmd_full = 1'b0;
        c0 = total_consumed - cons_base;
        wait_consumed(c0 + 50, 1000);
        check("bp_resume", ((total_consumed - cons_base) >= c0 + 50) ? 1 : 0, 1);
        check("underrun_still_set", underrun, 1);

        // Reset is the only way to clear underrun
        @(posedge clk); #1 reset = 1'b1; data_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_underrun_clr", underrun, 0);
        check("reset_valid_clr", data_valid, 0);
        check("reset_cmd_en", p1_cmd_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
